inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of fetch-pair entries (power of two, >=2).
REQ-002 SHALL provide ports, one per line, in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- pcF1  in  32  current fetch PC from next-PC logic.
- pcF2  in  32  current fetch PC + 4 from next-PC logic.
- flush  in  1  redirect; discard all fetched and in-flight instructions.
- stall  out  1  PC hold to next-PC logic EN; 1 = hold, 0 = advance.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  read address; memory returns words at addr and addr+4.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  64  [31:0] word at imem_addr, [63:32] word at imem_addr+4.
- dec_valid  out  1  head entry valid to decode.
- dec_ready  in  1  decode accepts head entry.
- dec_pc  out  32  PC of dec_inst1.
- dec_inst1  out  32  instruction at dec_pc.
- dec_inst2  out  32  instruction at dec_pc+4.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT and DROP.
REQ-004 IDLE: if flush=0 and count<DEPTH, SHALL capture pcF1 into imem_addr and enter WAIT next cycle; otherwise SHALL stay in IDLE.
REQ-005 imem_req SHALL be registered: 1 exactly while in WAIT or DROP; imem_addr SHALL hold stable for that whole time.
REQ-006 WAIT, imem_rvalid=1, flush=0: SHALL push {imem_addr, imem_rdata[31:0], imem_rdata[63:32]} at the tail and return to IDLE.
REQ-007 WAIT, flush=1, imem_rvalid=0: SHALL enter DROP.
REQ-008 WAIT, flush=1, imem_rvalid=1: SHALL discard the response and return to IDLE.
REQ-009 DROP: SHALL discard the first imem_rvalid response and return to IDLE; flush in DROP SHALL keep DROP.
REQ-010 stall SHALL be combinational: 0 when flush=1, or when state=WAIT and imem_rvalid=1; 1 otherwise.
REQ-011 dec_valid SHALL equal (count!=0); dec_pc, dec_inst1 and dec_inst2 SHALL be driven from the head entry.
REQ-012 Pop SHALL occur when dec_valid=1, dec_ready=1 and flush=0; head pointer SHALL advance by one.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged.
REQ-014 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-015 A request SHALL only issue when count<DEPTH, so a WAIT-state push never overflows.
REQ-016 flush SHALL set count, head and tail to 0 next cycle, taking priority over push and pop; dec_valid SHALL be 0 the cycle after flush.
REQ-017 Minimum latency: pcF1 sampled in IDLE at cycle N; imem_req=1 at N+1; earliest imem_rvalid at N+1; entry visible on dec_valid at N+2.
REQ-018 imem_rvalid outside WAIT or DROP SHALL be ignored.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=IDLE, count=0, head=0, tail=0, imem_req=0, imem_addr=0 and dec_valid=0; stall SHALL read 1; queue storage need not be cleared.
REQ-020 Reset mid-request SHALL abandon the outstanding read; the first response after reset release SHALL be ignored unless a new request is in WAIT.

Verification
REQ-021 Reset with pcF1=0x0001_0000 and memory latency 1 -> imem_addr=0x0001_0000 and imem_req=1 one cycle after release; stall=0 on the rvalid cycle; dec_pc=0x0001_0000 with both instructions correct.
REQ-022 dec_ready=0 with continuous fetch, DEPTH=4 -> exactly 4 entries pushed; stall then held at 1 and imem_req at 0 indefinitely; one pop -> exactly one new request.
REQ-023 flush during WAIT with rvalid 3 cycles later -> stall=0 for only the flush cycle; DROP entered; late data not enqueued; next request uses the redirected pcF1.
REQ-024 flush and imem_rvalid in the same cycle with count=2 -> count=0, response discarded, IDLE next cycle.
REQ-025 Simultaneous push and pop at count=DEPTH-1 across pointer wrap -> count stays 3; FIFO order of dec_pc preserved (0x10000, 0x10008, 0x10010, ...).
REQ-026 rst_n asserted mid-WAIT -> outputs at reset values within the same cycle, without waiting for a clock edge; stray rvalid after release does not enqueue.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Paired-word instruction fetch FIFO with request/drop FSM.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcF1,
  input  logic [31:0] pcF2,
  input  logic        flush,
  output logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst1,
  output logic [31:0] dec_inst2
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);
  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_WAIT = 2'd1;
  localparam logic [1:0]       c_DROP = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [c_AW:0]   r_count;
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [31:0]     r_pc_mem    [DEPTH];
  logic [31:0]     r_inst1_mem [DEPTH];
  logic [31:0]     r_inst2_mem [DEPTH];
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_unused;

  // The memory returns both words of the pair itself, so PC+4 is not needed.
  assign w_unused = ^pcF2;

  assign w_issue = (r_state == c_IDLE) && !flush && (r_count < c_FULL);
  assign w_push  = (r_state == c_WAIT) && imem_rvalid && !flush;
  assign w_pop   = (r_count != '0) && dec_ready && !flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_issue) w_state_nxt = c_WAIT;
      c_WAIT: begin
        if (imem_rvalid)  w_state_nxt = c_IDLE;
        else if (flush)   w_state_nxt = c_DROP;
      end
      c_DROP: if (imem_rvalid) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt != c_IDLE);
      if (w_issue) r_addr <= pcF1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left uninitialised; dec_valid gates its use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]    <= r_addr;
      r_inst1_mem[r_tail] <= imem_rdata[31:0];
      r_inst2_mem[r_tail] <= imem_rdata[63:32];
    end
  end

  assign stall     = !(flush || ((r_state == c_WAIT) && imem_rvalid));
  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign dec_valid = (r_count != '0);
  assign dec_pc    = r_pc_mem[r_head];
  assign dec_inst1 = r_inst1_mem[r_head];
  assign dec_inst2 = r_inst2_mem[r_head];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Directed self-checking bench for inst_fetch_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] pcF1;
  logic [31:0] pcF2;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst1;
  logic [31:0] dec_inst2;

  int          n_assert;
  int          n_fail;
  logic [31:0] flush_pc;
  logic [31:0] enq_pc;
  bit          enq_pending;
  logic [31:0] pc_q [$];

  inst_fetch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcF1       (pcF1),
    .pcF2       (pcF2),
    .flush      (flush),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_pc     (dec_pc),
    .dec_inst1  (dec_inst1),
    .dec_inst2  (dec_inst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag);
    if (pc_q.size() == 0) begin
      chk({tag, "_valid"}, {63'd0, dec_valid}, 64'd0);
    end else begin
      chk({tag, "_valid"}, {63'd0, dec_valid}, 64'd1);
      chk({tag, "_pc"},    {32'd0, dec_pc},    {32'd0, pc_q[0]});
      chk({tag, "_inst1"}, {32'd0, dec_inst1}, {32'd0, word(pc_q[0])});
      chk({tag, "_inst2"}, {32'd0, dec_inst2}, {32'd0, word(pc_q[0] + 32'd4)});
    end
  endtask

  // Drive a memory response for address a; enq says whether it should land in the queue.
  task automatic respond(input logic [31:0] a, input bit enq);
    imem_rvalid = 1'b1;
    imem_rdata  = {word(a + 32'd4), word(a)};
    enq_pc      = a;
    enq_pending = enq;
  endtask

  // One clock: models next-PC logic (advance by a pair, or redirect) and the expected queue.
  task automatic cyc();
    logic adv, fl, pop;
    @(negedge clk);
    adv = !stall;
    fl  = flush;
    pop = dec_ready && !flush && (pc_q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) pc_q.delete();
    else begin
      if (pop) void'(pc_q.pop_front());
      if (enq_pending) pc_q.push_back(enq_pc);
    end
    enq_pending = 1'b0;
    imem_rvalid = 1'b0;
    if (fl)       pcF1 = flush_pc;
    else if (adv) pcF1 = pcF1 + 32'd8;
    pcF2 = pcF1 + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; dec_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; enq_pc = '0; enq_pending = 1'b0;
    pcF1 = 32'h0001_0000; pcF2 = pcF1 + 32'd4;

    #12;
    chk("rst_req",   {63'd0, imem_req},  64'd0);
    chk("rst_addr",  {32'd0, imem_addr}, 64'd0);
    chk("rst_valid", {63'd0, dec_valid}, 64'd0);
    chk("rst_stall", {63'd0, stall},     64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First fetch, memory latency 1
    cyc();
    chk("first_req",  {63'd0, imem_req},  64'd1);
    chk("first_addr", {32'd0, imem_addr}, 64'h0001_0000);
    respond(32'h0001_0000, 1'b1);
    #1 chk("first_stall", {63'd0, stall}, 64'd0);
    cyc();
    chk_head("first_head");
    chk("first_req_drop", {63'd0, imem_req}, 64'd0);

    // Fill to DEPTH with decode stalled
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fill_req",  {63'd0, imem_req},  64'd1);
      chk("fill_addr", {32'd0, imem_addr}, {32'd0, 32'h0001_0008 + 32'(8 * i)});
      respond(32'h0001_0008 + 32'(8 * i), 1'b1);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("full_req",   {63'd0, imem_req}, 64'd0);
      chk("full_stall", {63'd0, stall},    64'd1);
    end
    chk_head("full_head");

    // One pop releases exactly one request
    dec_ready = 1'b1; cyc(); dec_ready = 1'b0;
    chk_head("pop1_head");
    chk("pop1_req_idle", {63'd0, imem_req}, 64'd0);
    cyc();
    chk("pop1_req",  {63'd0, imem_req},  64'd1);
    chk("pop1_addr", {32'd0, imem_addr}, 64'h0001_0020);
    respond(32'h0001_0020, 1'b1);
    cyc(); cyc(); cyc();
    chk("refull_req",   {63'd0, imem_req}, 64'd0);
    chk("refull_stall", {63'd0, stall},    64'd1);

    // Simultaneous push and pop at count 3 across pointer wrap
    dec_ready = 1'b1; cyc(); dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wrap_addr", {32'd0, imem_addr}, {32'd0, 32'h0001_0028 + 32'(8 * i)});
      respond(32'h0001_0028 + 32'(8 * i), 1'b1);
      dec_ready = 1'b1;
      #1 chk("wrap_stall", {63'd0, stall}, 64'd0);
      cyc();
      dec_ready = 1'b0;
      chk_head("wrap_head");
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_head("drain_head");
    end
    dec_ready = 1'b0;
    chk("drain_empty", {63'd0, dec_valid}, 64'd0);
    chk("drain_req",   {63'd0, imem_req},  64'd1);
    chk("drain_addr",  {32'd0, imem_addr}, 64'h0001_0050);

    // Flush during WAIT, late response 3 cycles later
    flush = 1'b1; flush_pc = 32'h2000_0000;
    #1 chk("fl_stall_on", {63'd0, stall}, 64'd0);
    cyc();
    flush = 1'b0;
    #1 chk("fl_stall_after", {63'd0, stall}, 64'd1);
    chk("drop_req",  {63'd0, imem_req},  64'd1);
    chk("drop_addr", {32'd0, imem_addr}, 64'h0001_0050);
    cyc(); cyc();
    respond(32'h0001_0050, 1'b0);
    #1 chk("drop_stall", {63'd0, stall}, 64'd1);
    cyc();
    chk("drop_noenq", {63'd0, dec_valid}, 64'd0);
    chk("drop_idle",  {63'd0, imem_req},  64'd0);
    cyc();
    chk("redir_req",  {63'd0, imem_req},  64'd1);
    chk("redir_addr", {32'd0, imem_addr}, 64'h2000_0000);

    // flush and rvalid together with count 2
    respond(32'h2000_0000, 1'b1); cyc(); cyc();
    chk("c2_addr1", {32'd0, imem_addr}, 64'h2000_0008);
    respond(32'h2000_0008, 1'b1); cyc(); cyc();
    chk("c2_addr2", {32'd0, imem_addr}, 64'h2000_0010);
    chk_head("c2_head");
    flush = 1'b1; flush_pc = 32'h3000_0000;
    respond(32'h2000_0010, 1'b0);
    #1 chk("c2_stall", {63'd0, stall}, 64'd0);
    cyc();
    flush = 1'b0;
    chk("c2_flushed", {63'd0, dec_valid}, 64'd0);
    chk("c2_idle",    {63'd0, imem_req},  64'd0);
    cyc();
    chk("c2_req",  {63'd0, imem_req},  64'd1);
    chk("c2_addr", {32'd0, imem_addr}, 64'h3000_0000);

    // Asynchronous reset mid-WAIT
    respond(32'h3000_0000, 1'b1); cyc(); cyc();
    chk("pre_rst_req",  {63'd0, imem_req},  64'd1);
    chk("pre_rst_addr", {32'd0, imem_addr}, 64'h3000_0008);
    chk_head("pre_rst_head");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   {63'd0, imem_req},  64'd0);
    chk("arst_addr",  {32'd0, imem_addr}, 64'd0);
    chk("arst_valid", {63'd0, dec_valid}, 64'd0);
    chk("arst_stall", {63'd0, stall},     64'd1);
    pc_q.delete();
    pcF1 = 32'h4000_0000; pcF2 = pcF1 + 32'd4;
    cyc();
    chk("in_rst_req", {63'd0, imem_req}, 64'd0);
    rst_n = 1'b1;
    respond(32'h3000_0008, 1'b0);
    cyc();
    chk("stray_noenq", {63'd0, dec_valid}, 64'd0);
    chk("post_req",    {63'd0, imem_req},  64'd1);
    chk("post_addr",   {32'd0, imem_addr}, 64'h4000_0000);
    respond(32'h4000_0000, 1'b1);
    cyc();
    chk_head("post_head");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
